// File: rtl/ksa_pkg.sv
// ksa_pkg: shared opcode type and pipeline-geometry helpers for the Kogge-Stone add/sub family.
package ksa_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_ADC = 2'd1,
        OP_SUB = 2'd2,
        OP_SBB = 2'd3
    } op_e;

    // Number of Kogge-Stone prefix levels for a given operand width (none for a 1-bit adder).
    function automatic int ksa_num_levels(input int width);
        int levels;
        if (width <= 1) begin
            levels = 0;
        end else begin
            levels = $clog2(width);
        end
        return levels;
    endfunction

    // Number of register stages: one per LEVELS_PER_STAGE levels, and never fewer than one.
    function automatic int ksa_num_stages(input int width, input int lps);
        int levels;
        int stages;
        levels = ksa_num_levels(width);
        if ((levels == 0) || (lps < 1)) begin
            stages = 1;
        end else begin
            stages = (levels + lps - 1) / lps;
        end
        return stages;
    endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// ksa_prefix_level: one combinational Kogge-Stone level combining (G,P) pairs DIST bits apart.
module ksa_prefix_level #(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o
);

    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        if (j < DIST) begin : g_pass
            // Low positions already hold their final group term at this level.
            assign g_o[j] = g_i[j];
            assign p_o[j] = p_i[j];
        end else begin : g_comb
            assign g_o[j] = g_i[j] | (p_i[j] & g_i[j-DIST]);
            assign p_o[j] = p_i[j] & p_i[j-DIST];
        end
    end

endmodule

// File: rtl/ksa_pipelined_addsub.sv
// ksa_pipelined_addsub: elastic, pipelined Kogge-Stone adder/subtractor with carry-in and flags.
module ksa_pipelined_addsub
    import ksa_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              in_op,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NUM_LVL = ksa_num_levels(WIDTH);
    localparam int NUM_STG = ksa_num_stages(WIDTH, LEVELS_PER_STAGE);
    localparam int LVL_ARR = (NUM_LVL > 0) ? NUM_LVL : 1;
    localparam int MID_ARR = (NUM_STG > 1) ? NUM_STG - 1 : 1;

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "ksa_pipelined_addsub: WIDTH must be >= 1");
    end
    if (LEVELS_PER_STAGE < 1) begin : g_bad_lps
        $fatal(1, "ksa_pipelined_addsub: LEVELS_PER_STAGE must be >= 1");
    end

    logic [WIDTH-1:0]   b_prep_s;
    logic [WIDTH-1:0]   g0_s;
    logic [WIDTH-1:0]   p0_s;
    logic               c0_s;
    logic [WIDTH-1:0]   lvl_gi_s [1:LVL_ARR];
    logic [WIDTH-1:0]   lvl_pi_s [1:LVL_ARR];
    logic [WIDTH-1:0]   lvl_go_s [1:LVL_ARR];
    logic [WIDTH-1:0]   lvl_po_s [1:LVL_ARR];
    logic [WIDTH-1:0]   mid_g_q  [0:MID_ARR-1];
    logic [WIDTH-1:0]   mid_p_q  [0:MID_ARR-1];
    logic [WIDTH-1:0]   mid_p0_q [0:MID_ARR-1];
    logic               mid_c0_q [0:MID_ARR-1];
    logic [NUM_STG-1:0] stg_valid_q;
    logic [NUM_STG-1:0] load_s;

    // Operand preparation: subtraction inverts B, and the opcode picks the carry-in.
    always_comb begin : p_prep
        b_prep_s = in_b;
        c0_s     = 1'b0;
        case (in_op)
            OP_ADD: begin
                b_prep_s = in_b;
                c0_s     = 1'b0;
            end
            OP_ADC: begin
                b_prep_s = in_b;
                c0_s     = in_cin;
            end
            OP_SUB: begin
                b_prep_s = ~in_b;
                c0_s     = 1'b1;
            end
            OP_SBB: begin
                b_prep_s = ~in_b;
                c0_s     = in_cin;
            end
            default: begin
                b_prep_s = in_b;
                c0_s     = 1'b0;
            end
        endcase
        p0_s    = in_a ^ b_prep_s;
        g0_s    = in_a & b_prep_s;
        // Folding c0 into bit 0 makes every final G bit the true carry out of that position.
        g0_s[0] = g0_s[0] | (p0_s[0] & c0_s);
    end

    // Elastic load enables: a stage advances when empty or when its successor advances.
    always_comb begin : p_load_chain
        logic ready_chain;
        ready_chain = out_ready;
        load_s      = '0;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            ready_chain = ~stg_valid_q[k] | ready_chain;
            load_s[k]   = ready_chain;
        end
    end

    assign in_ready  = load_s[0];
    assign out_valid = stg_valid_q[NUM_STG-1];

    if (NUM_LVL == 0) begin : g_no_levels
        assign lvl_gi_s[1] = '0;
        assign lvl_pi_s[1] = '0;
        assign lvl_go_s[1] = '0;
        assign lvl_po_s[1] = '0;
    end else begin : g_levels
        for (genvar i = 1; i <= NUM_LVL; i++) begin : g_lvl
            if (i == 1) begin : g_src_prep
                assign lvl_gi_s[i] = g0_s;
                assign lvl_pi_s[i] = p0_s;
            end else if (((i - 1) % LEVELS_PER_STAGE) == 0) begin : g_src_reg
                assign lvl_gi_s[i] = mid_g_q[(i - 1) / LEVELS_PER_STAGE - 1];
                assign lvl_pi_s[i] = mid_p_q[(i - 1) / LEVELS_PER_STAGE - 1];
            end else begin : g_src_chain
                assign lvl_gi_s[i] = lvl_go_s[i-1];
                assign lvl_pi_s[i] = lvl_po_s[i-1];
            end
            ksa_prefix_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << (i - 1))
            ) u_level (
                .g_i (lvl_gi_s[i]),
                .p_i (lvl_pi_s[i]),
                .g_o (lvl_go_s[i]),
                .p_o (lvl_po_s[i])
            );
        end
    end

    if (NUM_STG == 1) begin : g_no_mid
        assign mid_g_q[0]  = '0;
        assign mid_p_q[0]  = '0;
        assign mid_p0_q[0] = '0;
        assign mid_c0_q[0] = 1'b0;
    end

    for (genvar k = 0; k < NUM_STG; k++) begin : g_stage
        localparam int LAST_LVL = (((k + 1) * LEVELS_PER_STAGE) < NUM_LVL) ?
                                  ((k + 1) * LEVELS_PER_STAGE) : NUM_LVL;
        logic             valid_up_s;
        logic             valid_d;
        logic             valid_q;
        logic [WIDTH-1:0] p0_up_s;
        logic             c0_up_s;
        logic [WIDTH-1:0] g_end_s;

        if (k == 0) begin : g_up_in
            assign valid_up_s = in_valid;
            assign p0_up_s    = p0_s;
            assign c0_up_s    = c0_s;
        end else begin : g_up_mid
            assign valid_up_s = stg_valid_q[k-1];
            assign p0_up_s    = mid_p0_q[k-1];
            assign c0_up_s    = mid_c0_q[k-1];
        end

        if (NUM_LVL == 0) begin : g_end_prep
            assign g_end_s = g0_s;
        end else begin : g_end_lvl
            assign g_end_s = lvl_go_s[LAST_LVL];
        end

        // Stage valid follows its upstream whenever the stage is allowed to load.
        always_comb begin : p_valid_next
            if (load_s[k]) begin
                valid_d = valid_up_s;
            end else begin
                valid_d = valid_q;
            end
        end

        // Stage valid flop; reset empties the whole pipe.
        always_ff @(posedge clk or negedge rst_n) begin : p_valid_reg
            if (!rst_n) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
            end
        end

        assign stg_valid_q[k] = valid_q;

        if (k < NUM_STG - 1) begin : g_mid
            logic [WIDTH-1:0] g_d, g_q, p_d, p_q, p0_d, p0_q;
            logic             c0_d, c0_q;

            // Capture the partial prefix state only when a real beat advances.
            always_comb begin : p_mid_next
                if (load_s[k] && valid_up_s) begin
                    g_d  = g_end_s;
                    p_d  = lvl_po_s[LAST_LVL];
                    p0_d = p0_up_s;
                    c0_d = c0_up_s;
                end else begin
                    g_d  = g_q;
                    p_d  = p_q;
                    p0_d = p0_q;
                    c0_d = c0_q;
                end
            end

            // Intermediate stage data flops.
            always_ff @(posedge clk or negedge rst_n) begin : p_mid_reg
                if (!rst_n) begin
                    g_q  <= '0;
                    p_q  <= '0;
                    p0_q <= '0;
                    c0_q <= 1'b0;
                end else begin
                    g_q  <= g_d;
                    p_q  <= p_d;
                    p0_q <= p0_d;
                    c0_q <= c0_d;
                end
            end

            assign mid_g_q[k]  = g_q;
            assign mid_p_q[k]  = p_q;
            assign mid_p0_q[k] = p0_q;
            assign mid_c0_q[k] = c0_q;
        end else begin : g_last
            logic [WIDTH:0]   carry_s;
            logic [WIDTH-1:0] sum_s, sum_d, sum_q;
            logic             cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;

            // carry_s[j] is the carry into bit j; the top entry is the carry out of the MSB.
            assign carry_s = {g_end_s, c0_up_s};
            assign sum_s   = p0_up_s ^ carry_s[WIDTH-1:0];

            // Result and flags are captured with the beat and held until it is accepted.
            always_comb begin : p_last_next
                if (load_s[k] && valid_up_s) begin
                    sum_d  = sum_s;
                    cout_d = carry_s[WIDTH];
                    ovf_d  = carry_s[WIDTH] ^ carry_s[WIDTH-1];
                    zero_d = ~|sum_s;
                end else begin
                    sum_d  = sum_q;
                    cout_d = cout_q;
                    ovf_d  = ovf_q;
                    zero_d = zero_q;
                end
            end

            // Output result flops.
            always_ff @(posedge clk or negedge rst_n) begin : p_last_reg
                if (!rst_n) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else begin
                    sum_q  <= sum_d;
                    cout_q <= cout_d;
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end

            assign out_sum  = sum_q;
            assign out_cout = cout_q;
            assign out_ovf  = ovf_q;
            assign out_zero = zero_q;
        end
    end

endmodule

// File: tb/tb_ksa_pipelined_addsub.sv
// tb_ksa_pipelined_addsub: self-checking bench for the pipelined Kogge-Stone add/sub.
module tb_ksa_pipelined_addsub;
    import ksa_pkg::*;

    localparam int W  = 16;
    localparam int S  = 2;
    localparam int W5 = 5;
    localparam int S5 = 3;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    op_e           in_op = OP_ADD;
    logic          in_cin = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_sum;
    logic          out_cout, out_ovf, out_zero;

    logic          w5_in_valid = 1'b0;
    logic          w5_in_ready;
    op_e           w5_in_op = OP_ADD;
    logic          w5_in_cin = 1'b0;
    logic [W5-1:0] w5_in_a = '0;
    logic [W5-1:0] w5_in_b = '0;
    logic          w5_out_valid;
    logic          w5_out_ready = 1'b1;
    logic [W5-1:0] w5_out_sum;
    logic          w5_out_cout, w5_out_ovf, w5_out_zero;

    int n_checks = 0;
    int n_fail   = 0;

    ksa_pipelined_addsub #(.WIDTH(W), .LEVELS_PER_STAGE(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_cin(in_cin), .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    ksa_pipelined_addsub #(.WIDTH(W5), .LEVELS_PER_STAGE(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(w5_in_valid), .in_ready(w5_in_ready), .in_op(w5_in_op),
        .in_cin(w5_in_cin), .in_a(w5_in_a), .in_b(w5_in_b), .out_valid(w5_out_valid),
        .out_ready(w5_out_ready), .out_sum(w5_out_sum), .out_cout(w5_out_cout),
        .out_ovf(w5_out_ovf), .out_zero(w5_out_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain wide-integer arithmetic on (a + b' + c0) with signed overflow from operand signs.
    function automatic exp_t ref_calc(input int w, input logic [1:0] op, input logic [63:0] a,
                                      input logic [63:0] b, input logic cin);
        exp_t        r;
        logic [63:0] mask, am, bb;
        logic [64:0] full;
        logic        c0;
        mask   = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am     = a & mask;
        bb     = (op[1] ? ~b : b) & mask;
        c0     = (op == 2'd0) ? 1'b0 : ((op == 2'd2) ? 1'b1 : cin);
        full   = {1'b0, am} + {1'b0, bb} + {64'd0, c0};
        r.sum  = full[63:0] & mask;
        r.cout = full[w];
        r.ovf  = (am[w-1] == bb[w-1]) && (r.sum[w-1] != am[w-1]);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    function automatic logic [63:0] pick_operand(input int w);
        logic [63:0] mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 9))
            0:       return 64'd0;
            1:       return mask;
            2:       return 64'd1 << (w - 1);
            3:       return mask >> 1;
            default: return {$urandom, $urandom} & mask;
        endcase
    endfunction

    task automatic send_one(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, output int lat);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_op     = op_e'(op);
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b sum=%h c=%b v=%b z=%b, want all zero",
                     out_valid, out_sum, out_cout, out_ovf, out_zero);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_add_wrap();
        int lat;
        send_one(2'd0, 16'hFFFF, 16'h0001, 1'b0, lat);
        n_checks++;
        if (lat !== S) begin
            n_fail++;
            $display("FAIL add_latency: got %0d want %0d", lat, S);
        end
        n_checks++;
        if ({out_sum, out_cout, out_ovf, out_zero} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_wrap: got sum=%h c=%b v=%b z=%b want sum=0000 c=1 v=0 z=1",
                     out_sum, out_cout, out_ovf, out_zero);
        end
    endtask

    task automatic test_sub_ops();
        int lat;
        send_one(2'd2, 16'h8000, 16'h0001, 1'b0, lat);
        n_checks++;
        if ({out_sum, out_cout, out_ovf, out_zero} !== {16'h7FFF, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_ovf: got sum=%h c=%b v=%b z=%b want sum=7fff c=1 v=1 z=0",
                     out_sum, out_cout, out_ovf, out_zero);
        end
        send_one(2'd3, 16'h0000, 16'h0000, 1'b0, lat);
        n_checks++;
        if ({out_sum, out_cout, out_ovf, out_zero} !== {16'hFFFF, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sbb_borrow: got sum=%h c=%b v=%b z=%b want sum=ffff c=0 v=0 z=0",
                     out_sum, out_cout, out_ovf, out_zero);
        end
        send_one(2'd1, 16'h7FFF, 16'h0000, 1'b1, lat);
        n_checks++;
        if ({out_sum, out_cout, out_ovf, out_zero} !== {16'h8000, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL adc_cin: got sum=%h c=%b v=%b z=%b want sum=8000 c=0 v=1 z=0",
                     out_sum, out_cout, out_ovf, out_zero);
        end
        send_one(2'd0, 16'h0001, 16'h0001, 1'b1, lat);
        n_checks++;
        if ({out_sum, out_cout, out_ovf, out_zero} !== {16'h0002, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_ignores_cin: got sum=%h c=%b v=%b z=%b want sum=0002 c=0 v=0 z=0",
                     out_sum, out_cout, out_ovf, out_zero);
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            in_valid  = (i < 8);
            in_op     = op_e'(2'($urandom_range(0, 3)));
            in_a      = 16'(pick_operand(W));
            in_b      = 16'(pick_operand(W));
            in_cin    = 1'($urandom_range(0, 1));
            out_ready = 1'b1;
            @(negedge clk);
            if (i < 8) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready cycle %0d: got %b want 1", i, in_ready);
                end
            end
            n_checks++;
            if (out_valid !== ((i >= S) && (i < 8 + S))) begin
                n_fail++;
                $display("FAIL b2b_out_valid cycle %0d: got %b want %b", i, out_valid,
                         ((i >= S) && (i < 8 + S)));
            end
            if (out_valid && q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if ({out_sum, out_cout, out_ovf, out_zero} !== {e.sum[15:0], e.cout, e.ovf, e.zero}) begin
                    n_fail++;
                    $display("FAIL b2b_result cycle %0d: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                             i, out_sum, out_cout, out_ovf, out_zero, e.sum[15:0], e.cout, e.ovf, e.zero);
                end
            end
            if (in_valid && in_ready) q.push_back(ref_calc(W, in_op, {48'd0, in_a}, {48'd0, in_b}, in_cin));
        end
    endtask

    task automatic test_backpressure();
        exp_t         q[$];
        exp_t         e;
        int           accepted = 0;
        int           drained = 0;
        logic [W-1:0] held = '0;
        logic         have_held = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_op     = op_e'(2'($urandom_range(0, 3)));
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_cin    = 1'($urandom_range(0, 1));
            out_ready = 1'b0;
            @(negedge clk);
            if (out_valid && have_held) begin
                n_checks++;
                if (out_sum !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold cycle %0d: got sum=%h want %h", i, out_sum, held);
                end
            end else if (out_valid) begin
                held      = out_sum;
                have_held = 1'b1;
            end
            if (i >= S) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready cycle %0d: got %b want 0", i, in_ready);
                end
            end
            if (in_valid && in_ready) begin
                accepted++;
                q.push_back(ref_calc(W, in_op, {48'd0, in_a}, {48'd0, in_b}, in_cin));
            end
        end
        n_checks++;
        if (accepted != S) begin
            n_fail++;
            $display("FAIL stall_accepted: got %0d beats want %0d", accepted, S);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            if (out_valid && q.size() > 0) begin
                e = q.pop_front();
                drained++;
                n_checks++;
                if ({out_sum, out_cout, out_ovf, out_zero} !== {e.sum[15:0], e.cout, e.ovf, e.zero}) begin
                    n_fail++;
                    $display("FAIL drain_result %0d: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                             drained, out_sum, out_cout, out_ovf, out_zero, e.sum[15:0], e.cout, e.ovf, e.zero);
                end
            end
        end
        n_checks++;
        if (drained != S) begin
            n_fail++;
            $display("FAIL drain_count: got %0d beats want %0d", drained, S);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_op     = OP_ADD;
            in_a      = 16'h1234;
            in_b      = 16'h4321;
            out_ready = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got valid=%b sum=%h c=%b v=%b z=%b, want all zero",
                     out_valid, out_sum, out_cout, out_ovf, out_zero);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_stale cycle %0d: got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_random_stream();
        exp_t q[$];
        exp_t e;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk); #1;
            in_valid  = (i < 640) && ($urandom_range(0, 3) != 0);
            in_op     = op_e'(2'($urandom_range(0, 3)));
            in_a      = 16'(pick_operand(W));
            in_b      = 16'(pick_operand(W));
            in_cin    = 1'($urandom_range(0, 1));
            out_ready = (i >= 640) || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream16_extra cycle %0d: got beat sum=%h, want no beat", i, out_sum);
                end else begin
                    e = q.pop_front();
                    if ({out_sum, out_cout, out_ovf, out_zero} !== {e.sum[15:0], e.cout, e.ovf, e.zero}) begin
                        n_fail++;
                        $display("FAIL stream16 cycle %0d: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                                 i, out_sum, out_cout, out_ovf, out_zero, e.sum[15:0], e.cout, e.ovf, e.zero);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(ref_calc(W, in_op, {48'd0, in_a}, {48'd0, in_b}, in_cin));
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL stream16_lost: got %0d beats outstanding want 0", q.size());
        end
    endtask

    task automatic test_width5_stream();
        exp_t q[$];
        exp_t e;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk); #1;
            w5_in_valid  = (i == 0) || ((i < 640) && ($urandom_range(0, 3) != 0));
            w5_in_op     = op_e'(2'($urandom_range(0, 3)));
            w5_in_a      = 5'(pick_operand(W5));
            w5_in_b      = 5'(pick_operand(W5));
            w5_in_cin    = 1'($urandom_range(0, 1));
            w5_out_ready = (i < 8) || (i >= 640) || ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (i <= S5) begin
                n_checks++;
                if (w5_out_valid !== (i == S5)) begin
                    n_fail++;
                    $display("FAIL w5_latency cycle %0d: got out_valid=%b want %b", i, w5_out_valid, (i == S5));
                end
            end
            if (w5_out_valid && w5_out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream5_extra cycle %0d: got beat sum=%h, want no beat", i, w5_out_sum);
                end else begin
                    e = q.pop_front();
                    if ({w5_out_sum, w5_out_cout, w5_out_ovf, w5_out_zero} !== {e.sum[4:0], e.cout, e.ovf, e.zero}) begin
                        n_fail++;
                        $display("FAIL stream5 cycle %0d: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                                 i, w5_out_sum, w5_out_cout, w5_out_ovf, w5_out_zero, e.sum[4:0], e.cout, e.ovf, e.zero);
                    end
                end
            end
            if (w5_in_valid && w5_in_ready)
                q.push_back(ref_calc(W5, w5_in_op, {59'd0, w5_in_a}, {59'd0, w5_in_b}, w5_in_cin));
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL stream5_lost: got %0d beats outstanding want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sub_ops();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random_stream();
        test_width5_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
